// File: rtl/ifetch_unit.sv
// ifetch_unit: per-core instruction fetch over a one-cycle registered IM read,
// presenting one- or two-word instructions through a valid/ready handshake.
// Optional feature macro IFU_FETCH_CNT_EN adds a 32-bit accepted-instruction counter port.
module ifetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'd0,
  parameter logic [15:0] OPC_LDAC  = 16'd5,
  parameter logic [15:0] OPC_JPNZ  = 16'd28,
  parameter logic [15:0] OPC_JPPZ  = 16'd30,
  parameter logic [15:0] OPC_ENDOP = 16'd42
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] im_addr,
  input  logic [15:0] im_data,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir_opcode,
  output logic [15:0] ir_operand,
  output logic        ir_has_operand,
  output logic [15:0] ir_pc,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  output logic        halted
`ifdef IFU_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    OPC   = 3'd1,
    OPR   = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_next_q, pc_next_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] opc_q, opc_d;
  logic [15:0] opr_q, opr_d;
  logic [15:0] irpc_q, irpc_d;
  logic        has_q, has_d;
  logic        accept;

  function automatic logic is_operand_opcode(input logic [15:0] opc);
    return (opc == OPC_LDAC) || (opc == OPC_JPNZ) || (opc == OPC_JPPZ);
  endfunction

  assign accept = (state_q == VALID) && ir_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    addr_d    = addr_q;
    opc_d     = opc_q;
    opr_d     = opr_q;
    irpc_d    = irpc_q;
    has_d     = has_q;
    case (state_q)
      FETCH: begin
        addr_d  = pc_q;
        state_d = OPC;
      end
      OPC: begin
        // im_data here answers the FETCH address; the operand word is requested now
        addr_d = pc_q + 16'd1;
        opc_d  = im_data;
        irpc_d = pc_q;
        if (is_operand_opcode(im_data)) begin
          has_d   = 1'b1;
          state_d = OPR;
        end else begin
          has_d     = 1'b0;
          opr_d     = 16'd0;
          pc_next_d = pc_q + 16'd1;
          state_d   = VALID;
        end
      end
      OPR: begin
        opr_d     = im_data;
        pc_next_d = pc_q + 16'd2;
        state_d   = VALID;
      end
      VALID: begin
        if (accept) begin
          if (opc_q == OPC_ENDOP) begin
            // a halting instruction never redirects, even with jump_en set
            pc_d    = pc_next_q;
            state_d = HALT;
          end else begin
            pc_d    = jump_en ? jump_target : pc_next_q;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      pc_next_q <= RESET_PC;
      addr_q    <= RESET_PC;
      opc_q     <= 16'd0;
      opr_q     <= 16'd0;
      irpc_q    <= 16'd0;
      has_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      addr_q    <= addr_d;
      opc_q     <= opc_d;
      opr_q     <= opr_d;
      irpc_q    <= irpc_d;
      has_q     <= has_d;
    end
  end

  assign im_addr        = addr_d;
  assign ir_valid       = (state_q == VALID);
  assign halted         = (state_q == HALT);
  assign ir_opcode      = opc_q;
  assign ir_operand     = opr_q;
  assign ir_has_operand = has_q;
  assign ir_pc          = irpc_q;

`ifdef IFU_FETCH_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else if (accept) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: table of instructions loaded into a registered IM model,
// expected records queued at load time and compared as the unit presents them.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] im_addr;
  logic [15:0] im_data = 16'd0;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic [15:0] ir_opcode;
  logic [15:0] ir_operand;
  logic        ir_has_operand;
  logic [15:0] ir_pc;
  logic        jump_en = 1'b0;
  logic [15:0] jump_target = 16'd0;
  logic        halted;
`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  always @(posedge clk) im_data <= mem[im_addr];

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_opcode      (ir_opcode),
    .ir_operand     (ir_operand),
    .ir_has_operand (ir_has_operand),
    .ir_pc          (ir_pc),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .halted         (halted)
`ifdef IFU_FETCH_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] opc;
    logic [15:0] opr;
    logic        has;
    logic        jmp;
    logic [15:0] tgt;
    int          stall;
    logic [15:0] nxt;
  } vec_t;

  vec_t tbl [10];
  vec_t exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ends at the negedge where rst drops: that is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    ir_ready = 1'b1;
    jump_en = 1'b0;
    jump_target = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", ir_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_opcode", ir_opcode, 0);
    chk("rst_operand", ir_operand, 0);
    chk("rst_has_operand", ir_has_operand, 0);
    chk("rst_ir_pc", ir_pc, 0);
    rst = 1'b0;
  endtask

  task automatic run_prog(input int lo, input int hi);
    vec_t        e;
    logic [15:0] a;
    logic [15:0] pc1;
    int          cyc;
    int          fstart;
    int          gap_exp;
    int          acc;
    bit          first;
    bit          done;
    for (int i = lo; i < hi; i++) begin
      mem[tbl[i].pc] = tbl[i].opc;
      if (tbl[i].has) begin
        a = tbl[i].pc + 16'd1;
        mem[a] = tbl[i].opr;
      end
      exp_q.push_back(tbl[i]);
    end
    do_reset();
    cyc = 0;
    first = 1'b1;
    done = 1'b0;
    acc = 0;
    while (exp_q.size() > 0 && !done) begin
      e = exp_q.pop_front();
      pc1 = e.pc + 16'd1;
      fstart = first ? 0 : 1;
      while (!ir_valid && cyc < 12) begin
        if (cyc == fstart) chk("fetch_addr", im_addr, e.pc);
        if (cyc == fstart + 1) chk("opc_addr", im_addr, pc1);
        @(negedge clk);
        cyc++;
        jump_en = 1'b1;
        jump_target = 16'hDEAD;
      end
      if (!ir_valid) begin
        chk("valid_timeout", 0, 1);
        done = 1'b1;
      end else begin
        gap_exp = (first ? 2 : 3) + (e.has ? 1 : 0);
        chk("valid_latency", cyc, gap_exp);
        chk("opcode", ir_opcode, e.opc);
        chk("operand", ir_operand, e.has ? e.opr : 16'd0);
        chk("has_operand", ir_has_operand, e.has);
        chk("ir_pc", ir_pc, e.pc);
        chk("valid_im_addr", im_addr, pc1);
        if (e.stall > 0) begin
          ir_ready = 1'b0;
          for (int s = 0; s < e.stall; s++) begin
            @(negedge clk);
            jump_en = 1'b1;
            jump_target = 16'hDEAD;
            chk("stall_valid", ir_valid, 1);
            chk("stall_opcode", ir_opcode, e.opc);
            chk("stall_operand", ir_operand, e.has ? e.opr : 16'd0);
            chk("stall_ir_pc", ir_pc, e.pc);
            chk("stall_im_addr", im_addr, pc1);
          end
        end
        ir_ready = 1'b1;
        jump_en = e.jmp;
        jump_target = e.tgt;
        @(negedge clk);
        acc++;
        cyc = 1;
        first = 1'b0;
        jump_en = 1'b1;
        jump_target = 16'hDEAD;
        if (e.opc == 16'd42) begin
          chk("halted_after_endop", halted, 1);
          chk("valid_after_endop", ir_valid, 0);
          for (int h = 0; h < 20; h++) begin
            @(negedge clk);
            chk("halt_valid_low", ir_valid, 0);
            chk("halt_im_addr_frozen", im_addr, pc1);
          end
          chk("halt_still_halted", halted, 1);
`ifdef IFU_FETCH_CNT_EN
          chk("fetch_count", fetch_count, acc);
`endif
          done = 1'b1;
        end else begin
          chk("next_pc_addr", im_addr, e.nxt);
        end
      end
    end
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    //        pc        opc      opr        has   jmp   tgt       stall nxt
    tbl[0] = '{16'd0,    16'd33, 16'd0,     1'b0, 1'b0, 16'd0,    0,   16'd1};
    tbl[1] = '{16'd1,    16'd5,  16'd7,     1'b1, 1'b0, 16'd0,    5,   16'd3};
    tbl[2] = '{16'd3,    16'd28, 16'd20,    1'b1, 1'b0, 16'd0,    0,   16'd5};
    tbl[3] = '{16'd5,    16'd1,  16'd0,     1'b0, 1'b1, 16'd10,   0,   16'd10};
    tbl[4] = '{16'd10,   16'd28, 16'd20,    1'b1, 1'b1, 16'd20,   0,   16'd20};
    tbl[5] = '{16'd20,   16'd30, 16'hBEEF,  1'b1, 1'b0, 16'd0,    2,   16'd22};
    tbl[6] = '{16'd22,   16'd42, 16'd0,     1'b0, 1'b1, 16'd0,    0,   16'd23};
    // second program: LDAC at 0xFFFF takes its operand from address 0
    tbl[7] = '{16'd0,    16'd1,  16'd0,     1'b0, 1'b1, 16'hFFFF, 0,   16'hFFFF};
    tbl[8] = '{16'hFFFF, 16'd5,  16'd1,     1'b1, 1'b0, 16'd0,    0,   16'd1};
    tbl[9] = '{16'd1,    16'd42, 16'd0,     1'b0, 1'b0, 16'd0,    0,   16'd2};

    run_prog(0, 7);
    run_prog(7, 10);

    // reset while the operand read is in flight
    mem[0] = 16'd5;
    mem[1] = 16'h0077;
    do_reset();
    @(negedge clk);
    chk("opr_c1_addr", im_addr, 1);
    @(negedge clk);
    chk("opr_c2_valid", ir_valid, 0);
    chk("opr_c2_opcode", ir_opcode, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("opr_rst_valid", ir_valid, 0);
    chk("opr_rst_operand", ir_operand, 0);
    chk("opr_rst_opcode", ir_opcode, 0);
    chk("opr_rst_im_addr", im_addr, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("opr_restart_valid", ir_valid, 1);
    chk("opr_restart_operand", ir_operand, 16'h0077);
    chk("opr_restart_opcode", ir_opcode, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
